// File: rtl/fp_minmax_reduce.sv
// Streaming FP32 min/max reducer. Drives an external registered FP comparator
// one compare per element and returns the extreme value, its index, count and sticky invalid.
module fp_minmax_reduce #(
  parameter int W       = 32,
  parameter int CMP_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             s_valid,
  input  logic [W-1:0]     s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic [W-1:0]     cmp_in1,
  output logic [W-1:0]     cmp_in2,
  output logic             cmp_act,
  input  logic             cmp_eq,
  input  logic             cmp_great,
  input  logic             cmp_less,
  input  logic             cmp_inv,
  output logic             res_valid,
  output logic [W-1:0]     res_data,
  output logic [CNT_W-1:0] res_index,
  output logic [CNT_W-1:0] res_count,
  output logic             res_inv,
  input  logic             res_ready
);

  localparam int LAT_W = $clog2(CMP_LAT + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, FETCH, CMP, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       best_q, best_d;
  logic [CNT_W-1:0]   best_idx_q, best_idx_d;
  logic [CNT_W-1:0]   cand_idx_q, cand_idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               inv_q, inv_d;
  logic               mode_q, mode_d;
  logic               cand_last_q, cand_last_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [W-1:0]       cmp_in1_q, cmp_in1_d;
  logic [W-1:0]       cmp_in2_q, cmp_in2_d;
  logic               cmp_act_q, cmp_act_d;
  logic               res_valid_q, res_valid_d;
  logic [W-1:0]       res_data_q, res_data_d;
  logic [CNT_W-1:0]   res_index_q, res_index_d;
  logic [CNT_W-1:0]   res_count_q, res_count_d;
  logic               res_inv_q, res_inv_d;

  logic               take;
  logic [W-1:0]       sel_best;
  logic [CNT_W-1:0]   sel_idx;
  logic               sel_inv;

  assign s_ready = rst && (state_q == IDLE || state_q == FETCH);

  always_comb begin
    // cmp_in1_q doubles as the candidate register; it is held through WAIT.
    take     = (mode_q ? cmp_less : cmp_great);
    sel_best = take ? cmp_in1_q : best_q;
    sel_idx  = take ? cand_idx_q : best_idx_q;
    sel_inv  = inv_q | cmp_inv;

    state_d     = state_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    cand_idx_d  = cand_idx_q;
    count_d     = count_q;
    inv_d       = inv_q;
    mode_d      = mode_q;
    cand_last_d = cand_last_q;
    lat_cnt_d   = lat_cnt_q;
    cmp_in1_d   = cmp_in1_q;
    cmp_in2_d   = cmp_in2_q;
    cmp_act_d   = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_index_d = res_index_q;
    res_count_d = res_count_q;
    res_inv_d   = res_inv_q;

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          best_d     = s_data;
          best_idx_d = '0;
          count_d    = CNT_W'(1);
          inv_d      = 1'b0;
          mode_d     = mode;
          if (s_last) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = s_data;
            res_index_d = '0;
            res_count_d = CNT_W'(1);
            res_inv_d   = 1'b0;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (s_valid) begin
          cand_last_d = s_last;
          cand_idx_d  = count_q;
          count_d     = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
          cmp_in1_d   = s_data;
          cmp_in2_d   = best_q;
          cmp_act_d   = 1'b1;
          state_d     = CMP;
        end
      end
      CMP: begin
        lat_cnt_d = LAT_W'(1);
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == LAT_W'(CMP_LAT)) begin
          best_d     = sel_best;
          best_idx_d = sel_idx;
          inv_d      = sel_inv;
          if (cand_last_q) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = sel_best;
            res_index_d = sel_idx;
            res_count_d = count_q;
            res_inv_d   = sel_inv;
          end else begin
            state_d = FETCH;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      best_q      <= '0;
      best_idx_q  <= '0;
      cand_idx_q  <= '0;
      count_q     <= '0;
      inv_q       <= 1'b0;
      mode_q      <= 1'b0;
      cand_last_q <= 1'b0;
      lat_cnt_q   <= '0;
      cmp_in1_q   <= '0;
      cmp_in2_q   <= '0;
      cmp_act_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
      res_count_q <= '0;
      res_inv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      cand_idx_q  <= cand_idx_d;
      count_q     <= count_d;
      inv_q       <= inv_d;
      mode_q      <= mode_d;
      cand_last_q <= cand_last_d;
      lat_cnt_q   <= lat_cnt_d;
      cmp_in1_q   <= cmp_in1_d;
      cmp_in2_q   <= cmp_in2_d;
      cmp_act_q   <= cmp_act_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_index_q <= res_index_d;
      res_count_q <= res_count_d;
      res_inv_q   <= res_inv_d;
    end
  end

  assign cmp_in1   = cmp_in1_q;
  assign cmp_in2   = cmp_in2_q;
  assign cmp_act   = cmp_act_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_index = res_index_q;
  assign res_count = res_count_q;
  assign res_inv   = res_inv_q;

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Bench for fp_minmax_reduce: CMP_LAT=1 comparator model plus a result scoreboard.
module tb_fp_minmax_reduce;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] cmp_in1, cmp_in2;
  logic        cmp_act;
  logic        cmp_eq = 1'b0, cmp_great = 1'b0, cmp_less = 1'b0, cmp_inv = 1'b0;
  logic        res_valid;
  logic [31:0] res_data;
  logic [15:0] res_index, res_count;
  logic        res_inv;
  logic        res_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  fp_minmax_reduce #(.W(32), .CMP_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .cmp_in1(cmp_in1), .cmp_in2(cmp_in2), .cmp_act(cmp_act),
    .cmp_eq(cmp_eq), .cmp_great(cmp_great), .cmp_less(cmp_less), .cmp_inv(cmp_inv),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
    .res_count(res_count), .res_inv(res_inv), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Comparator model: flags valid in the cycle after the act strobe.
  int cyc = 0;
  int act_total = 0;
  int inv_at = -1;
  int act_cyc[$];

  function automatic int fcmp(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ka, kb;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 2;
    if (a[30:0] == 0 && b[30:0] == 0) return 0;
    ka = a[31] ? ~a : (a | 32'h8000_0000);
    kb = b[31] ? ~b : (b | 32'h8000_0000);
    if (ka > kb) return 1;
    if (ka < kb) return -1;
    return 0;
  endfunction

  always @(posedge clk) begin
    int r;
    cyc <= cyc + 1;
    cmp_eq <= 1'b0; cmp_great <= 1'b0; cmp_less <= 1'b0; cmp_inv <= 1'b0;
    if (rst && cmp_act) begin
      r = fcmp(cmp_in1, cmp_in2);
      cmp_eq    <= (r == 0);
      cmp_great <= (r == 1);
      cmp_less  <= (r == -1);
      cmp_inv   <= (act_total + 1 == inv_at);
      act_total <= act_total + 1;
      act_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [15:0] idx;
    logic [15:0] cnt;
    logic        inv;
  } exp_t;
  exp_t sb[$];

  task automatic send_elem(input logic [31:0] d, input logic last, input logic m);
    bit ok = 0;
    s_valid = 1'b1; s_data = d; s_last = last; mode = m;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout elem=%h got=no_accept exp=accept", d);
    end
  endtask

  task automatic send_packet(input logic [31:0] d[4], input int n, input logic m, input exp_t e);
    sb.push_back(e);
    for (int i = 0; i < n; i++) send_elem(d[i], (i == n - 1), m);
  endtask

  task automatic get_result(input string name, input int stall);
    exp_t e;
    logic [31:0] hd;
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s res_valid_timeout got=0 exp=1", name);
      return;
    end
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s unexpected_result got=%h exp=none", name, res_data);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (res_data !== e.data) begin failures++; $display("FAIL %s res_data got=%h exp=%h", name, res_data, e.data); end
    checks++;
    if (res_index !== e.idx) begin failures++; $display("FAIL %s res_index got=%0d exp=%0d", name, res_index, e.idx); end
    checks++;
    if (res_count !== e.cnt) begin failures++; $display("FAIL %s res_count got=%0d exp=%0d", name, res_count, e.cnt); end
    checks++;
    if (res_inv !== e.inv) begin failures++; $display("FAIL %s res_inv got=%b exp=%b", name, res_inv, e.inv); end
    hd = res_data;
    if (stall > 0) begin
      s_valid = 1'b1; s_data = 32'h4120_0000; s_last = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== hd || s_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s stall_cycle%0d got valid=%b data=%h s_ready=%b exp valid=1 data=%h s_ready=0",
                   name, i, res_valid, res_data, s_ready, hd);
        end
      end
      s_valid = 1'b0; s_last = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s after_handshake got valid=%b s_ready=%b exp valid=0 s_ready=1", name, res_valid, s_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmp_in1 !== 0 || cmp_in2 !== 0 || cmp_act !== 0 || res_valid !== 0 || res_data !== 0 ||
        res_index !== 0 || res_count !== 0 || res_inv !== 0 || s_ready !== 0) begin
      failures++;
      $display("FAIL reset_values got in1=%h in2=%h act=%b rv=%b rd=%h ri=%0d rc=%0d rinv=%b srdy=%b exp all 0",
               cmp_in1, cmp_in2, cmp_act, res_valid, res_data, res_index, res_count, res_inv, s_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_max();
    logic [31:0] p[4] = '{32'h4040_0000, 32'h3F80_0000, 32'h40A0_0000, 32'h4000_0000};
    int a0 = act_cyc.size();
    send_packet(p, 4, 1'b0, '{32'h40A0_0000, 16'd2, 16'd4, 1'b0});
    get_result("max", 0);
    checks++;
    if (act_cyc.size() - a0 != 3) begin
      failures++;
      $display("FAIL max_act_pulses got=%0d exp=3", act_cyc.size() - a0);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (act_cyc[a0 + i] - act_cyc[a0 + i - 1] != 3) begin
          failures++;
          $display("FAIL max_act_spacing%0d got=%0d exp=3", i, act_cyc[a0 + i] - act_cyc[a0 + i - 1]);
        end
      end
    end
  endtask

  task automatic test_min();
    logic [31:0] p[4] = '{32'h4040_0000, 32'h3F80_0000, 32'h40A0_0000, 32'h4000_0000};
    send_packet(p, 4, 1'b1, '{32'h3F80_0000, 16'd1, 16'd4, 1'b0});
    get_result("min", 0);
  endtask

  task automatic test_ties();
    logic [31:0] p[4] = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h0};
    send_packet(p, 3, 1'b0, '{32'h4000_0000, 16'd0, 16'd3, 1'b0});
    get_result("ties", 0);
  endtask

  task automatic test_invalid();
    logic [31:0] p[4] = '{32'h3F80_0000, 32'h7FC0_0000, 32'h4040_0000, 32'h0};
    inv_at = act_total + 2;
    send_packet(p, 3, 1'b0, '{32'h4040_0000, 16'd2, 16'd3, 1'b1});
    get_result("inv_second", 0);
    // Invalid on the first compare only must still be reported at the end.
    inv_at = act_total + 1;
    send_packet(p, 3, 1'b0, '{32'h4040_0000, 16'd2, 16'd3, 1'b1});
    get_result("inv_sticky", 0);
    inv_at = -1;
  endtask

  task automatic test_single();
    int a0 = act_cyc.size();
    sb.push_back('{32'hC000_0000, 16'd0, 16'd1, 1'b0});
    send_elem(32'hC000_0000, 1'b1, 1'b0);
    checks++;
    if (res_valid !== 1'b1) begin failures++; $display("FAIL single_latency got=%b exp=1", res_valid); end
    get_result("single", 0);
    checks++;
    if (act_cyc.size() != a0) begin
      failures++;
      $display("FAIL single_no_act got=%0d exp=0", act_cyc.size() - a0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] p[4] = '{32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0};
    send_packet(p, 2, 1'b0, '{32'h4000_0000, 16'd1, 16'd2, 1'b0});
    get_result("stall", 5);
  endtask

  task automatic test_reset_mid();
    logic [31:0] p[4] = '{32'h4000_0000, 32'hC000_0000, 32'h3F80_0000, 32'h0};
    send_elem(32'h4040_0000, 1'b0, 1'b0);
    send_elem(32'h3F80_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (cmp_in1 !== 0 || cmp_in2 !== 0 || cmp_act !== 0 || res_valid !== 0 || res_data !== 0 ||
        res_index !== 0 || res_count !== 0 || res_inv !== 0 || s_ready !== 0) begin
      failures++;
      $display("FAIL midreset_values got in1=%h in2=%h act=%b rv=%b rd=%h ri=%0d rc=%0d rinv=%b srdy=%b exp all 0",
               cmp_in1, cmp_in2, cmp_act, res_valid, res_data, res_index, res_count, res_inv, s_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL midreset_no_result got=%b exp=0", res_valid); end
    send_packet(p, 3, 1'b1, '{32'hC000_0000, 16'd1, 16'd3, 1'b0});
    get_result("after_reset", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_max();
    test_min();
    test_ties();
    test_invalid();
    test_single();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
